// File: rtl/memory8x8_fsm_pkg.sv
// Shared types and default sizes for the 8x8 register-file memory and its control FSM.
package memory8x8_fsm_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } fsm_state_t;

endpackage

// File: rtl/memory8x8_fsm_if.sv
// Host-side bus of the memory: operation request, address/data and the FSM strobes.
interface memory8x8_fsm_if #(
    parameter int DATA_WIDTH = memory8x8_fsm_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = memory8x8_fsm_pkg::ADDR_WIDTH
);
    // Level handshake: selFSM/op are sampled every rising edge; valid/rw are
    // the resulting Moore strobes, and data_out is mem[address] at all times.
    logic                  selFSM;
    logic                  op;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  rw;

    modport master (
        output selFSM, op, address, data_in,
        input  data_out, valid, rw
    );

    modport slave (
        input  selFSM, op, address, data_in,
        output data_out, valid, rw
    );
endinterface

// File: rtl/memory8x8_fsm_ctrl.sv
// Control FSM: maps the level request (sel, op) to registered Moore strobes valid/rw.
module memory8x8_fsm_ctrl
    import memory8x8_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       op,
    output logic       valid,
    output logic       rw,
    output fsm_state_t state
);

    fsm_state_t state_q;
    fsm_state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every state is left on every edge; the request alone picks the next one.
    always_comb begin
        state_d = IDLE;
        if (sel) begin
            state_d = op ? WRITE : READ;
        end
    end

    always_comb begin
        valid = 1'b0;
        rw    = 1'b0;
        case (state_q)
            WRITE: begin
                valid = 1'b1;
                rw    = 1'b1;
            end
            READ: begin
                valid = 1'b1;
                rw    = 1'b0;
            end
            default: begin
                valid = 1'b0;
                rw    = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/memory8x8_fsm.sv
// Register-file memory with synchronous write (in WRITE state) and asynchronous read.
module memory8x8_fsm #(
    parameter int DATA_WIDTH = memory8x8_fsm_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = memory8x8_fsm_pkg::ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    memory8x8_fsm_if.slave                bus,
    output memory8x8_fsm_pkg::fsm_state_t dbg_state
);
    import memory8x8_fsm_pkg::*;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  valid;
    logic                  rw;
    logic                  wr_en;
    fsm_state_t            state;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    memory8x8_fsm_ctrl u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .sel   (bus.selFSM),
        .op    (bus.op),
        .valid (valid),
        .rw    (rw),
        .state (state)
    );

    // The write uses the address/data present at the edge that ends the WRITE cycle.
    assign wr_en = valid & rw;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[bus.address] = bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.data_out = mem_q[bus.address];
    assign bus.valid    = valid;
    assign bus.rw       = rw;
    assign dbg_state    = state;

endmodule

// File: tb/tb_memory8x8_fsm.sv
// Directed self-checking bench for memory8x8_fsm.
module tb_memory8x8_fsm;
    import memory8x8_fsm_pkg::*;

    logic       clk;
    logic       rst;
    fsm_state_t dbg_state;
    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];

    memory8x8_fsm_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    memory8x8_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic op, input logic [2:0] addr, input logic [7:0] din);
        bus.selFSM  = sel;
        bus.op      = op;
        bus.address = addr;
        bus.data_in = din;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic read_at(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        bus.address = addr;
        #1;
        check(tag, bus.data_out, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;

        // Reset state
        check("reset_valid", {7'd0, bus.valid}, 8'h00);
        check("reset_rw", {7'd0, bus.rw}, 8'h00);
        check("reset_state", {6'd0, dbg_state}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            read_at($sformatf("reset_mem%0d", i), 3'(i), 8'h00);
        end

        // Write 0xAA to addr 0 for two cycles, then read for two cycles
        drive(1'b1, 1'b1, 3'd0, 8'hAA);
        step();
        check("wr0_valid", {7'd0, bus.valid}, 8'h01);
        check("wr0_rw", {7'd0, bus.rw}, 8'h01);
        check("wr0_prewrite", bus.data_out, 8'h00);
        step();
        check("wr0_committed", bus.data_out, 8'hAA);
        bus.op = 1'b0;
        step();
        step();
        check("rd0_valid", {7'd0, bus.valid}, 8'h01);
        check("rd0_rw", {7'd0, bus.rw}, 8'h00);
        check("rd0_data", bus.data_out, 8'hAA);

        // Same at addr 1 with 0x55, then drop selFSM
        drive(1'b1, 1'b1, 3'd1, 8'h55);
        step();
        step();
        bus.op = 1'b0;
        step();
        step();
        check("rd1_data", bus.data_out, 8'h55);
        drive(1'b0, 1'b0, 3'd0, 8'h55);
        step();
        check("idle_valid", {7'd0, bus.valid}, 8'h00);
        check("idle_state", {6'd0, dbg_state}, 8'h00);
        check("idle_addr0", bus.data_out, 8'hAA);
        read_at("idle_addr1", 3'd1, 8'h55);

        // Pattern i*0x11 to all addresses in back-to-back WRITE cycles
        drive(1'b1, 1'b1, 3'd0, 8'h00);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'(i), 8'(i * 8'h11));
            exp_q.push_back(8'(i * 8'h11));
            step();
        end
        bus.selFSM = 1'b0;
        repeat (3) step();
        bus.selFSM = 1'b1;
        bus.op     = 1'b0;
        step();
        check("sweep_read_valid", {7'd0, bus.valid}, 8'h01);
        check("sweep_read_rw", {7'd0, bus.rw}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            read_at($sformatf("sweep_mem%0d", i), 3'(i), exp_q.pop_front());
        end

        // Disabled FSM must not write even with op=1
        drive(1'b0, 1'b1, 3'd3, 8'hFF);
        repeat (4) step();
        check("nowr_valid", {7'd0, bus.valid}, 8'h00);
        check("nowr_addr3", bus.data_out, 8'h33);
        read_at("nowr_addr5", 3'd5, 8'h55);

        // Asynchronous reset between edges during WRITE
        drive(1'b1, 1'b1, 3'd2, 8'hC3);
        step();
        step();
        check("pre_rst_write", bus.data_out, 8'hC3);
        check("pre_rst_state", {6'd0, dbg_state}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {7'd0, bus.valid}, 8'h00);
        check("arst_rw", {7'd0, bus.rw}, 8'h00);
        check("arst_state", {6'd0, dbg_state}, 8'h00);
        check("arst_addr2", bus.data_out, 8'h00);
        for (int i = 0; i < 8; i++) begin
            read_at($sformatf("arst_mem%0d", i), 3'(i), 8'h00);
        end
        step();
        #2;
        rst = 1'b0;
        bus.selFSM = 1'b0;
        #1;
        read_at("post_rst_addr2", 3'd2, 8'h00);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
